// File: rtl/nmi_pf_pkg.sv
// Shared types and helpers for the NMI flash prefetch buffer.
// Default flash window base when the SoC build does not provide one.
`ifndef FLASH_START_ADDR
`define FLASH_START_ADDR 32'h3000_0000
`endif

package nmi_pf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } pf_state_e;

  localparam int DEF_LINE_WORDS = 4;

  function automatic int line_bytes_of(input int line_words);
    return line_words * 4;
  endfunction

  function automatic int idx_w_of(input int line_words);
    return $clog2(line_words);
  endfunction

  // Written as an offset compare so a window touching 2^32 does not overflow.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/nmi_if.sv
// NMI request/response bus: valid/ready handshake with address, write data and byte strobes.
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/nmi_pf_linebuf.sv
// One-line buffer: LINE_WORDS data words plus the tag and valid bit of the line they hold.
module nmi_pf_linebuf #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 28
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  input  logic             i_tag_set,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_tag_valid,
  input  logic             i_inval,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [31:0]      o_rd_data,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_valid
);

  logic [31:0]      r_data [LINE_WORDS];
  logic [TAG_W-1:0] r_tag;
  logic             r_valid;

  always_ff @(posedge clk_i) begin
    if (i_wr_en) r_data[i_wr_idx] <= i_wr_data;
  end

  // Completing a fill decides validity on its own, so it outranks a plain invalidate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else if (i_tag_set) begin
      r_tag   <= i_tag;
      r_valid <= i_tag_valid;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rd_data = r_data[i_rd_idx];
  assign o_tag     = r_tag;
  assign o_valid   = r_valid;

endmodule

// File: rtl/nmi_flash_prefetch.sv
// Single-line read buffer for XIP flash fetches between the core NMI port and the fabric.
// Cacheable read misses refill a whole line in ascending order; everything else passes through.
module nmi_flash_prefetch
  import nmi_pf_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = `FLASH_START_ADDR,
  parameter logic [31:0] FLASH_SIZE = 32'h0100_0000,
  parameter int          LINE_WORDS = DEF_LINE_WORDS,
  parameter int          CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             flush_i,
  nmi_if.slave             nmi_s,
  nmi_if.master            nmi_m,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int LINE_BYTES = line_bytes_of(LINE_WORDS);
  localparam int IDX_W      = idx_w_of(LINE_WORDS);
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = 32 - OFF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pf_state_e        r_state, w_next;
  logic [31:0]      r_addr, r_wdata;
  logic [3:0]       r_wstrb;
  logic [IDX_W-1:0] r_k;
  logic             r_fill_flush;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  logic             w_cacheable, w_tag_match;
  logic             w_hit, w_miss;
  logic             w_wr_en, w_tag_set, w_tag_valid, w_inval;
  logic [31:0]      w_buf_rdata;
  logic [TAG_W-1:0] w_buf_tag;
  logic             w_buf_valid;

  assign w_cacheable = en_i && (nmi_s.wstrb == 4'h0) &&
                       in_window(nmi_s.addr, FLASH_BASE, FLASH_SIZE);
  assign w_tag_match = w_buf_valid && (nmi_s.addr[31:OFF_W] == w_buf_tag);

  always_comb begin
    w_next       = r_state;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    w_wr_en      = 1'b0;
    w_tag_set    = 1'b0;
    w_tag_valid  = 1'b0;
    w_inval      = 1'b0;
    nmi_m.valid  = 1'b0;
    nmi_m.addr   = '0;
    nmi_m.wdata  = '0;
    nmi_m.wstrb  = '0;
    nmi_s.ready  = 1'b0;
    nmi_s.rdata  = '0;

    unique case (r_state)
      IDLE: begin
        if (nmi_s.valid) begin
          if (w_cacheable && w_tag_match) begin
            w_hit  = 1'b1;
            w_next = RESP;
          end else if (w_cacheable) begin
            // The old line is being overwritten word by word from here on.
            w_miss  = 1'b1;
            w_inval = 1'b1;
            w_next  = FILL;
          end else begin
            if ((nmi_s.wstrb != 4'h0) && w_tag_match) w_inval = 1'b1;
            w_next = PASS;
          end
        end
        if (flush_i) w_inval = 1'b1;
      end

      PASS: begin
        nmi_m.valid = 1'b1;
        nmi_m.addr  = r_addr;
        nmi_m.wdata = r_wdata;
        nmi_m.wstrb = r_wstrb;
        nmi_s.ready = nmi_m.ready;
        nmi_s.rdata = nmi_m.rdata;
        if (nmi_m.ready) w_next = IDLE;
        if (flush_i) w_inval = 1'b1;
      end

      FILL: begin
        nmi_m.valid = 1'b1;
        nmi_m.addr  = {r_addr[31:OFF_W], r_k, 2'b00};
        if (nmi_m.ready) begin
          w_wr_en = 1'b1;
          if (r_k == LAST_IDX) begin
            // A flush seen at any point of the fill leaves the line unusable.
            w_tag_set   = 1'b1;
            w_tag_valid = !(r_fill_flush || flush_i);
            w_next      = RESP;
          end
        end
      end

      RESP: begin
        nmi_s.ready = 1'b1;
        nmi_s.rdata = w_buf_rdata;
        w_next      = IDLE;
        if (flush_i) w_inval = 1'b1;
      end

      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_k          <= '0;
      r_fill_flush <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_hit) r_hit_cnt <= sat_inc(r_hit_cnt);
      if (w_miss) begin
        r_miss_cnt   <= sat_inc(r_miss_cnt);
        r_k          <= '0;
        r_fill_flush <= 1'b0;
      end else if (r_state == FILL) begin
        if (nmi_m.ready) r_k <= r_k + 1'b1;
        if (flush_i) r_fill_flush <= 1'b1;
      end
    end
  end

  // Request payload is held for PASS replay, FILL line base and RESP word index.
  always_ff @(posedge clk_i) begin
    if ((r_state == IDLE) && nmi_s.valid) begin
      r_addr  <= nmi_s.addr;
      r_wdata <= nmi_s.wdata;
      r_wstrb <= nmi_s.wstrb;
    end
  end

  nmi_pf_linebuf #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_linebuf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (r_k),
    .i_wr_data   (nmi_m.rdata),
    .i_tag_set   (w_tag_set),
    .i_tag       (r_addr[31:OFF_W]),
    .i_tag_valid (w_tag_valid),
    .i_inval     (w_inval),
    .i_rd_idx    (r_addr[OFF_W-1:2]),
    .o_rd_data   (w_buf_rdata),
    .o_tag       (w_buf_tag),
    .o_valid     (w_buf_valid)
  );

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

endmodule

// File: tb/tb_nmi_flash_prefetch.sv
// Bench for nmi_flash_prefetch: directed vector table, reset/saturation sequences, randomized traffic vs a transaction-level model.
module tb_nmi_flash_prefetch;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] SIZE = 32'h0100_0000;
  localparam int          LW   = 4;
  localparam int          CW   = 5;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] K    = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] hit_cnt, miss_cnt;

  nmi_if up ();
  nmi_if dn ();

  nmi_flash_prefetch #(
    .FLASH_BASE (BASE),
    .FLASH_SIZE (SIZE),
    .LINE_WORDS (LW),
    .CNT_W      (CW)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .flush_i    (flush),
    .nmi_s      (up),
    .nmi_m      (dn),
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
  );

  always #5 clk = ~clk;

  // Fabric model: ready after ds_lat wait cycles, rdata derived from the address.
  int ds_lat = 2;
  int ds_wait;
  assign dn.ready = dn.valid && (ds_wait >= ds_lat);
  assign dn.rdata = dn.addr ^ K;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds_wait <= 0;
    else if (dn.valid && !dn.ready) ds_wait <= ds_wait + 1;
    else ds_wait <= 0;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ds_t;
  ds_t ds_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  logic        pu_v, pu_r, pd_v, pd_r;
  logic [31:0] pd_addr, pd_wdata;
  logic [3:0]  pd_ws;

  always @(negedge clk) begin
    if (!rst_n) begin
      pu_v <= 1'b0; pu_r <= 1'b0; pd_v <= 1'b0; pd_r <= 1'b0;
      pd_addr <= '0; pd_wdata <= '0; pd_ws <= '0;
    end else begin
      assert (!(pu_v && !pu_r) || up.valid)
        else $error("upstream valid withdrawn before ready");
      if (pd_v && !pd_r) begin
        n_cmp++;
        if (!dn.valid || dn.addr !== pd_addr || dn.wstrb !== pd_ws || dn.wdata !== pd_wdata) begin
          n_fail++;
          $display("FAIL dn_hold: got valid=%b addr=%h wstrb=%h required addr=%h wstrb=%h held",
                   dn.valid, dn.addr, dn.wstrb, pd_addr, pd_ws);
        end
      end
      if (dn.valid && dn.ready) ds_q.push_back('{dn.addr, dn.wdata, dn.wstrb});
      pu_v <= up.valid; pu_r <= up.ready;
      pd_v <= dn.valid; pd_r <= dn.ready;
      pd_addr <= dn.addr; pd_wdata <= dn.wdata; pd_ws <= dn.wstrb;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One upstream transaction; flush pulses in cycle flush_at (cycle 0 = request cycle).
  task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int flush_at, output logic [31:0] rd, output int waited,
                         output int ds_n, output int ds_start, output logic mrdy);
    int j;
    ds_start = ds_q.size();
    rd = '0; mrdy = 1'b0;
    @(posedge clk); #1;
    up.valid = 1'b1; up.addr = a; up.wdata = wd; up.wstrb = ws;
    j = 0;
    forever begin
      @(negedge clk);
      flush = (j == flush_at);
      if (up.ready) begin
        rd = up.rdata; mrdy = dn.ready;
        break;
      end
      if (j > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL timeout: got no ready after %0d cycles required a response", j);
        j = -1;
        break;
      end
      j++;
    end
    waited = j;
    @(posedge clk); #1;
    up.valid = 1'b0; up.wstrb = '0; flush = 1'b0;
    ds_n = ds_q.size() - ds_start;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          flush_at;
    logic [31:0] rdata;
    int          wait_c;
    int          hit;
    int          miss;
    int          ds;
  } vec_t;
  vec_t vt[7];

  bit          m_v;
  logic [31:0] m_tag;
  int          m_hit, m_miss;

  // Transaction-level reference: classify the request, predict traffic, result and line state.
  task automatic model_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input bit rand_flush);
    bit          cache;
    int          kind;
    int          exp_wait, exp_ds, flush_at;
    logic [31:0] lb, exp_rd, rd;
    int          waited, ds_n, ds_s;
    logic        mrdy;
    cache = en && (ws == 4'h0) && (a >= BASE) && ((a - BASE) < SIZE);
    lb = a & ~32'hF;
    if (cache && m_v && m_tag == lb) begin
      kind = 0; exp_wait = 1; exp_ds = 0; exp_rd = (a & ~32'h3) ^ K;
    end else if (cache) begin
      kind = 1; exp_wait = LW * (ds_lat + 1) + 1; exp_ds = LW; exp_rd = (a & ~32'h3) ^ K;
    end else begin
      kind = 2; exp_wait = ds_lat + 1; exp_ds = 1; exp_rd = a ^ K;
    end
    flush_at = rand_flush ? int'($urandom_range(0, exp_wait)) : -1;
    run_req(a, wd, ws, flush_at, rd, waited, ds_n, ds_s, mrdy);
    if (kind == 0) m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
    if (kind == 1) begin
      m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
      m_v = 1'b1; m_tag = lb;
    end
    if (kind == 2 && ws != 4'h0 && m_v && m_tag == lb) m_v = 1'b0;
    if (flush_at >= 0 && !(kind == 1 && flush_at == 0)) m_v = 1'b0;
    check("rnd_rdata", rd, exp_rd);
    check("rnd_latency", waited, exp_wait);
    check("rnd_ds_count", ds_n, exp_ds);
    check("rnd_hit_cnt", {27'd0, hit_cnt}, m_hit);
    check("rnd_miss_cnt", {27'd0, miss_cnt}, m_miss);
    if (kind == 2 && ds_n == 1) begin
      check("rnd_pass_addr", ds_q[ds_s].addr, a);
      check("rnd_pass_wdata", ds_q[ds_s].wdata, wd);
      check("rnd_pass_wstrb", {28'd0, ds_q[ds_s].wstrb}, {28'd0, ws});
      check("rnd_pass_same_cycle", {31'd0, mrdy}, 32'd1);
    end
    if (kind == 1) begin
      for (int k = 0; k < LW && k < ds_n; k++) begin
        check("rnd_fill_addr", ds_q[ds_s + k].addr, lb + 32'(4 * k));
        check("rnd_fill_wstrb", {28'd0, ds_q[ds_s + k].wstrb}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    int          waited, ds_n, ds_s;
    logic        mrdy;

    up.valid = 1'b0; up.addr = '0; up.wdata = '0; up.wstrb = '0;

    vt[0] = '{32'h3000_0008, 32'h0, 4'h0, -1, 32'h95A5_A5AD, 13, 0, 1, 4};
    vt[1] = '{32'h3000_000C, 32'h0, 4'h0, -1, 32'h95A5_A5A9, 1, 1, 1, 0};
    vt[2] = '{32'h3000_0004, 32'h1234_5678, 4'hF, -1, 32'h95A5_A5A1, 3, 1, 1, 1};
    vt[3] = '{32'h3000_000C, 32'h0, 4'h0, -1, 32'h95A5_A5A9, 13, 1, 2, 4};
    vt[4] = '{32'h2000_0000, 32'h0, 4'h0, -1, 32'h85A5_A5A5, 3, 1, 2, 1};
    vt[5] = '{32'h3000_0010, 32'h0, 4'h0, 4, 32'h95A5_A5B5, 13, 1, 3, 4};
    vt[6] = '{32'h3000_0010, 32'h0, 4'h0, -1, 32'h95A5_A5B5, 13, 1, 4, 4};

    repeat (3) @(negedge clk);
    check("rst_dn_valid", {31'd0, dn.valid}, 32'd0);
    check("rst_dn_addr", dn.addr, 32'd0);
    check("rst_up_ready", {31'd0, up.ready}, 32'd0);
    check("rst_up_rdata", up.rdata, 32'd0);
    check("rst_hit_cnt", {27'd0, hit_cnt}, 32'd0);
    check("rst_miss_cnt", {27'd0, miss_cnt}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_req(vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].flush_at, rd, waited, ds_n, ds_s, mrdy);
      check("vec_rdata", rd, vt[i].rdata);
      check("vec_latency", waited, vt[i].wait_c);
      check("vec_hit_cnt", {27'd0, hit_cnt}, vt[i].hit);
      check("vec_miss_cnt", {27'd0, miss_cnt}, vt[i].miss);
      check("vec_ds_count", ds_n, vt[i].ds);
      for (int k = 0; k < ds_n && k < vt[i].ds; k++) begin
        if (vt[i].ds == LW) check("vec_fill_addr", ds_q[ds_s + k].addr,
                                  (vt[i].addr & ~32'hF) + 32'(4 * k));
        else begin
          check("vec_pass_addr", ds_q[ds_s + k].addr, vt[i].addr);
          check("vec_pass_wdata", ds_q[ds_s + k].wdata, vt[i].wdata);
          check("vec_pass_wstrb", {28'd0, ds_q[ds_s + k].wstrb}, {28'd0, vt[i].wstrb});
          check("vec_pass_same_cycle", {31'd0, mrdy}, 32'd1);
        end
      end
    end

    // Asynchronous reset in the middle of a refill.
    @(posedge clk); #1;
    up.valid = 1'b1; up.addr = 32'h3000_0040; up.wdata = '0; up.wstrb = '0;
    repeat (5) @(negedge clk);
    check("midfill_dn_valid_before", {31'd0, dn.valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midfill_rst_dn_valid", {31'd0, dn.valid}, 32'd0);
    check("midfill_rst_up_ready", {31'd0, up.ready}, 32'd0);
    check("midfill_rst_hit_cnt", {27'd0, hit_cnt}, 32'd0);
    check("midfill_rst_miss_cnt", {27'd0, miss_cnt}, 32'd0);
    up.valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; en = 1'b0;

    run_req(32'h3000_0000, 32'h0, 4'h0, -1, rd, waited, ds_n, ds_s, mrdy);
    check("dis_rdata", rd, 32'h95A5_A5A5);
    check("dis_latency", waited, 3);
    check("dis_ds_count", ds_n, 1);
    check("dis_hit_cnt", {27'd0, hit_cnt}, 32'd0);
    check("dis_miss_cnt", {27'd0, miss_cnt}, 32'd0);
    if (ds_n == 1) check("dis_pass_addr", ds_q[ds_s].addr, 32'h3000_0000);

    en = 1'b1; m_v = 1'b0; m_tag = '0; m_hit = 0; m_miss = 0;
    ds_lat = 2;
    model_req(32'h3000_0010, 32'h0, 4'h0, 1'b0);
    model_req(32'h3000_0020, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 35; i++) model_req(32'h3000_0024 + 32'(i % 3 * 4), 32'h0, 4'h0, 1'b0);
    check("sat_hit_cnt", {27'd0, hit_cnt}, CMAX);

    for (int i = 0; i < 220; i++) begin
      logic [31:0] wd;
      logic [3:0]  ws;
      ds_lat = $urandom_range(0, 3);
      en = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = BASE + ($urandom_range(0, 3) << 4) + $urandom_range(0, 15);
        4:          a = BASE + SIZE - 32'd16 + $urandom_range(0, 15);
        5:          a = BASE - 32'd16 + $urandom_range(0, 15);
        6:          a = BASE + SIZE + $urandom_range(0, 15);
        default:    a = $urandom;
      endcase
      ws = ($urandom_range(0, 9) < 7) ? 4'h0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      model_req(a, wd, ws, $urandom_range(0, 99) < 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nmi_flash_prefetch.md
Name: nmi_flash_prefetch

Overview:
- Single-line read buffer between the core wrapper's NMI master port and the SoC NMI fabric.
- Serves repeated flash reads (instruction fetch from the reset vector region) without re-accessing slow XIP flash.
- Refills a whole line of LINE_WORDS words from the fabric on a miss.
- Forwards all writes and non-flash accesses unchanged.

Parameters:
FLASH_BASE, `FLASH_START_ADDR, first byte address of the cacheable flash window
FLASH_SIZE, 32'h0100_0000, window size in bytes; power of two
LINE_WORDS, 4, words per line; power of two, 2..16
CNT_W, 16, width of the hit/miss counters

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  1 = buffering enabled; 0 = every request passes through
flush_i  in  1  single-cycle pulse; invalidates the line
nmi_s  nmi_if.slave  -  upstream, from the core bridge; fields valid, addr[31:0], wdata[31:0], wstrb[3:0], rdata[31:0], ready
nmi_m  nmi_if.master  -  downstream, to the fabric; same fields
hit_cnt_o  out  CNT_W  saturating count of buffered read hits
miss_cnt_o  out  CNT_W  saturating count of line refills

Behaviour:
- Clock/reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n_i.
- Reset values:
  - FSM = IDLE; line_valid = 0.
  - nmi_m.valid = 0; nmi_m.addr/wdata/wstrb = 0.
  - nmi_s.ready = 0; nmi_s.rdata = 0.
  - Both counters = 0.
- Reset mid-operation: in-flight transactions are abandoned and all outputs take reset values immediately.
- NMI rule, both sides: the master holds valid and payload stable until ready is high for one cycle. The next request may start the following cycle.
- Address classification:
  - cacheable = en_i && wstrb == 0 && FLASH_BASE <= addr < FLASH_BASE + FLASH_SIZE, unsigned 32-bit compare.
  - line_base = addr & ~(LINE_WORDS*4 - 1).
  - word index = addr[log2(LINE_WORDS*4)-1:2]; addr[1:0] is ignored.
- FSM states: IDLE, PASS, FILL, RESP.
- IDLE:
  - No upstream valid: stay in IDLE.
  - Cacheable hit (line_valid and tag match): go to RESP; hit_cnt++.
  - Cacheable miss: latch the line base; k = 0; go to FILL; miss_cnt++.
  - Otherwise: latch the request; go to PASS.
- PASS:
  - nmi_m carries the latched request.
  - nmi_s.ready and nmi_s.rdata follow nmi_m combinationally, in the same cycle.
  - On nmi_m.ready: return to IDLE.
  - A write whose line_base equals the buffered tag clears line_valid at acceptance.
- FILL:
  - nmi_m.valid = 1, addr = line_base + 4k, wstrb = 0.
  - On nmi_m.ready: buf[k] = nmi_m.rdata; k++. The next word's address is presented the following cycle with valid kept high.
  - After word LINE_WORDS-1: set tag; set line_valid unless flush_i was seen during the fill; go to RESP.
  - Words are always fetched in ascending order from line_base; there is no critical-word-first.
- RESP: nmi_s.ready = 1 for exactly one cycle with rdata = buf[index]; next state is IDLE.
- Hit latency: ready in the cycle after valid is first sampled.
- Miss latency: the sum of the downstream word latencies plus 1.
- flush_i:
  - In IDLE, PASS or RESP: line_valid = 0 next cycle.
  - During FILL: the current fill completes and answers correctly, but the line is left invalid.
- Flush and hit in the same IDLE cycle: the hit is served from the current data, then the line is invalidated.
- Counters: saturate at all-ones; no wrap.
- Upstream dropping valid before ready is a protocol violation; behaviour is undefined and flagged by a bench assertion.

Decomposition:
- Package nmi_pf_pkg:
  - state enum pf_state_e {IDLE, PASS, FILL, RESP}
  - function in_window(addr, base, size)
  - localparams LINE_BYTES and IDX_W derived from LINE_WORDS
- One natural sub-module, nmi_pf_linebuf: LINE_WORDS×32 register array with tag and valid bit, one write port (fill) and one read port (index). The FSM and counters stay in the top.

Test Plan:
Common bench setup: FLASH_BASE = 0x3000_0000, LINE_WORDS = 4; downstream model gives ready 2 cycles after valid with rdata = addr ^ 0xA5A5A5A5.
1. Cold read 0x3000_0008 -> downstream reads 0x3000_0000/04/08/0C in that order; upstream rdata 0x95A5A5AD; miss_cnt = 1; hit_cnt = 0.
2. Then read 0x3000_000C -> ready exactly 1 cycle after valid; no nmi_m.valid; rdata 0x95A5A5A9; hit_cnt = 1.
3. Write 0x3000_0004, wstrb 0xF, wdata 0x1234_5678 -> forwarded unchanged; the following read of 0x3000_000C refills and miss_cnt = 2.
4. Read 0x2000_0000 -> passthrough; upstream ready in the same cycle as downstream ready; rdata 0x85A5A5A5; counters unchanged.
5. flush_i pulse during the 2nd FILL word -> the response is still correct; a repeat read of the same address misses (miss_cnt increments).
6. rst_n_i low mid-FILL -> nmi_m.valid = 0 without waiting for a clock edge, counters = 0. After release, with en_i = 0, a read of 0x3000_0000 passes through with no counter change.
